ppu_ex_ctrl: RTL and testbench

PPU_EX_CTRL -- requirements
Module: ppu_ex_ctrl

---
 rtl/ppu_ex_ctrl_if.sv | 22 ++
 rtl/ppu_ex_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ppu_ex_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_ex_ctrl_if.sv
// PPU request/response bus between the EX-stage controller (master) and the PPU core (slave).
interface ppu_ex_ctrl_if #(
   parameter int unsigned PPU_OP_WIDTH = 3
);
   logic                    ppu_req_o;
   logic                    ppu_gnt_i;
   logic [PPU_OP_WIDTH-1:0] ppu_op_o;
   logic [31:0]             ppu_a_o;
   logic [31:0]             ppu_b_o;
   logic                    ppu_rvalid_i;
   logic [31:0]             ppu_rdata_i;

   modport master (
      output ppu_req_o, ppu_op_o, ppu_a_o, ppu_b_o,
      input  ppu_gnt_i, ppu_rvalid_i, ppu_rdata_i
   );

   modport slave (
      input  ppu_req_o, ppu_op_o, ppu_a_o, ppu_b_o,
      output ppu_gnt_i, ppu_rvalid_i, ppu_rdata_i
   );
endinterface

// File: rtl/ppu_ex_ctrl.sv
// EX-stage sequencer for posit (PPU) instructions: issues one request to the PPU,
// waits for the result, hands it to writeback and absorbs pipeline kills.
// Optional response watchdog enabled by defining PPU_TIMEOUT_EN.
module ppu_ex_ctrl #(
   parameter int unsigned PPU_OP_WIDTH   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ppu_en_i,
   input  logic [PPU_OP_WIDTH-1:0] ppu_operator_i,
   input  logic [31:0]             ppu_operand_a_i,
   input  logic [31:0]             ppu_operand_b_i,
   input  logic                    kill_i,
   ppu_ex_ctrl_if.master           ppu,
   output logic                    ppu_ready_o,
   output logic [31:0]             ppu_result_o,
   output logic                    illegal_op_o,
   output logic                    error_o,
   output logic                    busy_o
);

   localparam logic [PPU_OP_WIDTH-1:0] OP_MAX = PPU_OP_WIDTH'(4);
   localparam logic [31:0]             NAR    = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e state_q;
   logic   ready_q;
   logic   op_illegal;

   assign op_illegal = (ppu_operator_i > OP_MAX);

   // A kill arriving while the result is presented suppresses the handoff in that same cycle.
   assign ppu_ready_o = ready_q & ~kill_i;

   // Reject out-of-range watchdog limits at elaboration.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_timeout_range
      $error("ppu_ex_ctrl: TIMEOUT_CYCLES must be within 2..1023");
   end

`ifdef PPU_TIMEOUT_EN
   localparam int unsigned     CNT_W    = 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             error_q;
   logic             timeout;

   assign timeout = (cnt_q == CNT_LAST);
   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

   // Sequencer state, request payload and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ready_q       <= 1'b0;
         ppu_result_o  <= 32'h0;
         illegal_op_o  <= 1'b0;
         busy_o        <= 1'b0;
         ppu.ppu_req_o <= 1'b0;
         ppu.ppu_op_o  <= '0;
         ppu.ppu_a_o   <= 32'h0;
         ppu.ppu_b_o   <= 32'h0;
`ifdef PPU_TIMEOUT_EN
         cnt_q         <= '0;
         error_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ppu_en_i && !kill_i) begin
                  busy_o <= 1'b1;
                  if (op_illegal) begin
                     ppu_result_o <= 32'h0;
                     illegal_op_o <= 1'b1;
                     ready_q      <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     ppu.ppu_op_o  <= ppu_operator_i;
                     ppu.ppu_a_o   <= ppu_operand_a_i;
                     ppu.ppu_b_o   <= ppu_operand_b_i;
                     ppu.ppu_req_o <= 1'b1;
                     state_q       <= S_REQ;
                  end
               end
            end

            S_REQ: begin
               if (kill_i) begin
                  ppu.ppu_req_o <= 1'b0;
                  if (ppu.ppu_gnt_i) begin
                     // Granted request still owes a response; absorb it.
                     state_q <= S_DRAIN;
`ifdef PPU_TIMEOUT_EN
                     cnt_q   <= '0;
`endif
                  end else begin
                     state_q <= S_IDLE;
                     busy_o  <= 1'b0;
                  end
               end else if (ppu.ppu_gnt_i) begin
                  ppu.ppu_req_o <= 1'b0;
                  state_q       <= S_WAIT;
`ifdef PPU_TIMEOUT_EN
                  cnt_q         <= '0;
`endif
               end
            end

            S_WAIT: begin
               if (kill_i) begin
                  if (ppu.ppu_rvalid_i) begin
                     state_q <= S_IDLE;
                     busy_o  <= 1'b0;
                  end else begin
                     state_q <= S_DRAIN;
`ifdef PPU_TIMEOUT_EN
                     cnt_q   <= '0;
`endif
                  end
               end else if (ppu.ppu_rvalid_i) begin
                  ppu_result_o <= ppu.ppu_rdata_i;
                  ready_q      <= 1'b1;
                  state_q      <= S_DONE;
               end
`ifdef PPU_TIMEOUT_EN
               else if (timeout) begin
                  ppu_result_o <= NAR;
                  error_q      <= 1'b1;
                  ready_q      <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end

            S_DRAIN: begin
               if (ppu.ppu_rvalid_i) begin
                  state_q <= S_IDLE;
                  busy_o  <= 1'b0;
               end
`ifdef PPU_TIMEOUT_EN
               else if (timeout) begin
                  state_q <= S_IDLE;
                  busy_o  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end

            S_DONE: begin
               ready_q      <= 1'b0;
               illegal_op_o <= 1'b0;
`ifdef PPU_TIMEOUT_EN
               error_q      <= 1'b0;
`endif
               state_q      <= S_IDLE;
               busy_o       <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_ex_ctrl.sv
// Self-checking bench for ppu_ex_ctrl: directed vector table, randomized
// transactions against a transaction-level model, and hand-written corner sequences.
module tb_ppu_ex_ctrl;

   localparam int unsigned OPW = 3;
   localparam int unsigned TO  = 8;
   localparam int unsigned NV  = 10;

   logic           clk;
   logic           rst_n;
   logic           en;
   logic [OPW-1:0] op_s;
   logic [31:0]    a_s;
   logic [31:0]    b_s;
   logic           kill;
   logic           ready;
   logic [31:0]    result;
   logic           illegal;
   logic           error;
   logic           busy;

   int    n_tests = 0;
   int    n_fail  = 0;
   string cur_tag = "";

   ppu_ex_ctrl_if #(.PPU_OP_WIDTH(OPW)) pif ();

   ppu_ex_ctrl #(.PPU_OP_WIDTH(OPW), .TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ppu_en_i        (en),
      .ppu_operator_i  (op_s),
      .ppu_operand_a_i (a_s),
      .ppu_operand_b_i (b_s),
      .kill_i          (kill),
      .ppu             (pif),
      .ppu_ready_o     (ready),
      .ppu_result_o    (result),
      .illegal_op_o    (illegal),
      .error_o         (error),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          gd;        // request cycles before grant
      int          rd;        // wait cycles before rvalid
      logic [31:0] rdata;
      int          kmode;     // 0 none, 1 kill in REQ, 2 kill in WAIT
      int          kat;       // 1-based cycle within that state
      int          exp_ready;
      int          exp_lat;   // observations after capture edge until ready
      logic [31:0] exp_res;
      logic        exp_ill;
   } vec_t;

   vec_t vt [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %h expected %h", cur_tag, name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; kill = 1'b0; op_s = '0; a_s = '0; b_s = '0;
      pif.ppu_gnt_i = 1'b0; pif.ppu_rvalid_i = 1'b0; pif.ppu_rdata_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Drives one instruction and acts as the PPU; checks observed behaviour against expectations.
   task automatic run_txn(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input int gd, input int rd, input logic [31:0] rdata,
                          input int kmode, input int kat, input int exp_ready, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_ill);
      int          n_req, n_gnt, n_rdy, lat, wcnt, bad_pay, drain_bad, exp_gnt;
      bit          pend, drop, done, chk_idle;
      logic [31:0] res;
      logic        ill, err;
      n_req = 0; n_gnt = 0; n_rdy = 0; lat = -1; wcnt = 0; bad_pay = 0; drain_bad = 0;
      pend = 0; drop = 0; done = 0; chk_idle = 0;
      res = '0; ill = 1'b0; err = 1'b0;
      en = 1'b1; op_s = t_op; a_s = t_a; b_s = t_b; kill = 1'b0;
      pif.ppu_gnt_i = 1'b0; pif.ppu_rvalid_i = 1'b0;
      step();
      for (int j = 0; j < 60 && !done; j++) begin
         pif.ppu_gnt_i = 1'b0; pif.ppu_rvalid_i = 1'b0; kill = 1'b0;
         if (drop) en = 1'b0;
         if (chk_idle) begin
            if (busy !== 1'b0) drain_bad++;
            chk_idle = 0;
         end
         if (j > 0 && busy === 1'b0 && !pend) begin
            done = 1;
         end else begin
            if (pend) begin
               if (kmode == 2 && wcnt + 1 == kat && !drop) begin
                  kill = 1'b1; drop = 1;
               end
               if (wcnt == rd) begin
                  pif.ppu_rvalid_i = 1'b1; pif.ppu_rdata_i = rdata; pend = 0;
                  if (drop) chk_idle = 1;
               end else begin
                  wcnt++;
               end
            end
            if (pif.ppu_req_o === 1'b1) begin
               n_req++;
               if (pif.ppu_op_o !== t_op || pif.ppu_a_o !== t_a || pif.ppu_b_o !== t_b) bad_pay++;
               if (kmode == 1 && n_req == kat && !drop) begin
                  kill = 1'b1; drop = 1;
               end
               if (n_req == gd + 1) begin
                  pif.ppu_gnt_i = 1'b1; n_gnt++; pend = 1; wcnt = 0;
               end
            end
            #1;
            if (ready === 1'b1) begin
               n_rdy++;
               if (lat < 0) lat = j;
               res = result; ill = illegal; err = error; drop = 1;
            end
            step();
         end
      end
      idle_inputs();
      check("terminated", 32'(done), 32'd1);
      check("ready_count", 32'(n_rdy), 32'(exp_ready));
      if (exp_ready != 0) begin
         check("latency", 32'(lat), 32'(exp_lat));
         check("result", res, exp_res);
         check("illegal_op", 32'(ill), 32'(exp_ill));
         check("error", 32'(err), 32'd0);
      end
      exp_gnt = (exp_ill || (kmode == 1 && kat <= gd)) ? 0 : 1;
      check("grant_count", 32'(n_gnt), 32'(exp_gnt));
      if (exp_ill) check("req_never", 32'(n_req), 32'd0);
      check("payload_stable", 32'(bad_pay), 32'd0);
      check("idle_after_rvalid", 32'(drain_bad), 32'd0);
      check("final_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int          lat, gd, rd, km, kat;
      logic [2:0]  rop;
      logic [31:0] ra, rb, rdt;
      logic        rill;
      bit          seen_rdy;

      // Directed vectors: op, a, b, gd, rd, rdata, kmode, kat, exp_ready, exp_lat, exp_res, exp_ill
      vt[0] = '{3'd2, 32'h4000_0000, 32'h4000_0000, 0, 0, 32'h4800_0000, 0, 0, 1, 2, 32'h4800_0000, 1'b0};
      vt[1] = '{3'd6, 32'h1111_1111, 32'h2222_2222, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0, 1'b1};
      vt[2] = '{3'd0, 32'hCAFE_0001, 32'h0BAD_0002, 5, 1, 32'h1234_5678, 0, 0, 1, 8, 32'h1234_5678, 1'b0};
      vt[3] = '{3'd3, 32'h0000_0003, 32'h0000_0004, 0, 4, 32'h5555_5555, 2, 1, 0, 0, 32'h0, 1'b0};
      vt[4] = '{3'd1, 32'h0000_00A0, 32'h0000_00B0, 3, 0, 32'h6666_6666, 1, 1, 0, 0, 32'h0, 1'b0};
      vt[5] = '{3'd0, 32'h0000_0011, 32'h0000_0022, 2, 2, 32'h7777_7777, 1, 3, 0, 0, 32'h0, 1'b0};
      vt[6] = '{3'd2, 32'h0000_0033, 32'h0000_0044, 0, 2, 32'h8888_8888, 2, 3, 0, 0, 32'h0, 1'b0};
      vt[7] = '{3'd4, 32'h3F80_0000, 32'h0000_0000, 1, 3, 32'h4000_0000, 0, 0, 1, 6, 32'h4000_0000, 1'b0};
      vt[8] = '{3'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 1'b1};
      vt[9] = '{3'd7, 32'hCCCC_CCCC, 32'hDDDD_DDDD, 2, 2, 32'h0, 0, 0, 1, 0, 32'h0, 1'b1};

      idle_inputs();
      rst_n = 1'b0;
      #7;
      cur_tag = "reset";
      check("busy", 32'(busy), 32'd0);
      check("ready", 32'(ready), 32'd0);
      check("result", result, 32'h0);
      check("req", 32'(pif.ppu_req_o), 32'd0);
      check("payload", pif.ppu_a_o | pif.ppu_b_o | 32'(pif.ppu_op_o), 32'h0);
      check("flags", 32'({illegal, error}), 32'd0);
      do_reset();

      for (int i = 0; i < int'(NV); i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_txn(vt[i].op, vt[i].a, vt[i].b, vt[i].gd, vt[i].rd, vt[i].rdata, vt[i].kmode,
                 vt[i].kat, vt[i].exp_ready, vt[i].exp_lat, vt[i].exp_res, vt[i].exp_ill);
         step();
      end

      // Randomized transactions, expectations from the instruction-level rules.
      for (int i = 0; i < 40; i++) begin
         cur_tag = $sformatf("rand%0d", i);
         rop  = 3'($urandom_range(0, 7));
         ra   = $urandom; rb = $urandom; rdt = $urandom;
         gd   = int'($urandom_range(0, 4));
         rd   = int'($urandom_range(0, 4));
         rill = (rop > 3'd4);
         km   = int'($urandom_range(0, 3));
         km   = (rill || km < 2) ? 0 : km - 1;
         kat  = (km == 1) ? int'($urandom_range(1, gd + 1)) :
                (km == 2) ? int'($urandom_range(1, rd + 1)) : 0;
         run_txn(rop, ra, rb, gd, rd, rdt, km, kat, (km == 0) ? 1 : 0,
                 rill ? 0 : gd + rd + 2, rill ? 32'h0 : rdt, rill);
         if ($urandom_range(0, 1) == 1) step();
      end

      // Kill in IDLE blocks capture.
      cur_tag = "kill_idle";
      en = 1'b1; kill = 1'b1; op_s = 3'd0; a_s = 32'h9;
      step();
      check("busy", 32'(busy), 32'd0);
      check("req", 32'(pif.ppu_req_o), 32'd0);
      idle_inputs();
      step();

      // Kill while the result is presented suppresses ready.
      cur_tag = "kill_done";
      en = 1'b1; op_s = 3'd6;
      step();
      kill = 1'b1;
      #1;
      check("busy", 32'(busy), 32'd1);
      check("ready", 32'(ready), 32'd0);
      step();
      idle_inputs();
      check("busy_after", 32'(busy), 32'd0);
      step();

      // Back-to-back: next instruction captured right after DONE.
      cur_tag = "b2b";
      en = 1'b1; op_s = 3'd0; a_s = 32'h1; b_s = 32'h2;
      step();
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0; pif.ppu_rvalid_i = 1'b1; pif.ppu_rdata_i = 32'hAAAA_0001;
      step();
      pif.ppu_rvalid_i = 1'b0;
      #1;
      check("ready1", 32'(ready), 32'd1);
      check("result1", result, 32'hAAAA_0001);
      step();
      op_s = 3'd1; a_s = 32'h3; b_s = 32'h4;
      check("idle_gap", 32'(busy), 32'd0);
      step();
      check("req2", 32'(pif.ppu_req_o), 32'd1);
      check("payload2", {pif.ppu_a_o[15:0], pif.ppu_b_o[7:0], 5'd0, pif.ppu_op_o}, 32'h0003_0401);
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0; pif.ppu_rvalid_i = 1'b1; pif.ppu_rdata_i = 32'hBBBB_0002;
      step();
      pif.ppu_rvalid_i = 1'b0;
      #1;
      check("ready2", 32'(ready), 32'd1);
      check("result2", result, 32'hBBBB_0002);
      idle_inputs();
      step();
      step();

      // Asynchronous reset while waiting for the PPU; a late rvalid is ignored.
      cur_tag = "rst_wait";
      en = 1'b1; op_s = 3'd2; a_s = 32'h5; b_s = 32'h6;
      step();
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0;
      check("in_wait", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("busy", 32'(busy), 32'd0);
      check("req", 32'(pif.ppu_req_o), 32'd0);
      check("payload", pif.ppu_a_o | pif.ppu_b_o | 32'(pif.ppu_op_o), 32'h0);
      en = 1'b0;
      step();
      rst_n = 1'b1;
      pif.ppu_rvalid_i = 1'b1; pif.ppu_rdata_i = 32'hDEAD_BEEF;
      step();
      pif.ppu_rvalid_i = 1'b0;
      #1;
      check("late_busy", 32'(busy), 32'd0);
      check("late_ready", 32'(ready), 32'd0);
      check("late_result", result, 32'h0);
      step();

`ifdef PPU_TIMEOUT_EN
      // Watchdog: NaR after TO wait cycles, then silent drain timeout.
      cur_tag = "timeout_wait";
      en = 1'b1; op_s = 3'd0; a_s = 32'h7; b_s = 32'h8;
      step();
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0;
      lat = -1;
      for (int j = 1; j < 40 && lat < 0; j++) begin
         #1;
         if (ready === 1'b1) begin
            lat = j;
            check("result", result, 32'h8000_0000);
            check("error", 32'(error), 32'd1);
            check("illegal", 32'(illegal), 32'd0);
         end
         step();
      end
      check("latency", 32'(lat), 32'(TO + 1));
      en = 1'b0;
      check("error_cleared", 32'(error), 32'd0);
      step();
      cur_tag = "timeout_drain";
      en = 1'b1; op_s = 3'd0;
      step();
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0; kill = 1'b1;
      step();
      kill = 1'b0; en = 1'b0;
      lat = -1; seen_rdy = 0;
      for (int d = 0; d < 40 && lat < 0; d++) begin
         if (busy === 1'b0) lat = d;
         #1;
         if (ready === 1'b1) seen_rdy = 1;
         step();
      end
      check("drain_cycles", 32'(lat), 32'(TO));
      check("no_ready", 32'(seen_rdy), 32'd0);
`else
      // Without the watchdog a missing response keeps the controller busy.
      cur_tag = "no_timeout";
      en = 1'b1; op_s = 3'd0; a_s = 32'h7; b_s = 32'h8;
      step();
      pif.ppu_gnt_i = 1'b1;
      step();
      pif.ppu_gnt_i = 1'b0;
      lat = 0; seen_rdy = 0;
      for (int j = 0; j < 3 * int'(TO); j++) begin
         #1;
         if (busy !== 1'b1) lat++;
         if (ready === 1'b1) seen_rdy = 1;
         step();
      end
      check("busy_low_cycles", 32'(lat), 32'd0);
      check("no_ready", 32'(seen_rdy), 32'd0);
      check("error", 32'(error), 32'd0);
      do_reset();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global guard against a hung simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
